period_meter: RTL and testbench

Measures the period of a slow, asynchronous periodic signal in system-clock cycles. It is the inverse of the clock divider: the divider derives slow clocks from `clock`, and this block recovers the division ratio from a slow waveform. It is used to check divided-clock taps and external slow inputs on hardware. A measurement runs on request, and the result is returned through a valid/ready handshake.

---
 rtl/period_meter.sv | 108 ++++++++++
 tb/tb_period_meter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures the period of a slow asynchronous input in clock cycles, one measurement per start request.
// Latency: result one cycle after the closing rising edge. Backpressure: the result is held in DONE until out_ready; start is ignored outside IDLE.
module period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] period,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            period    <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    // A rise here is the opening edge; the count restarts so the closing rise reads the period.
                    if (rise) begin
                        state <= COUNT;
                        cnt   <= CNT_ONE;
                    end else if (cnt == CNT_PRE) begin
                        state     <= DONE;
                        cnt       <= CNT_MAX;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        period    <= CNT_MAX;
                        overflow  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                COUNT: begin
                    // Rise wins over timeout, so an all-ones count with a rise is a real (non-overflow) result.
                    if (rise) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        period    <= cnt;
                        overflow  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        period    <= CNT_MAX;
                        overflow  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter (CNT_W = 8): generated slow waveforms, expected results queued at start and compared on out_valid.
module tb_period_meter;

    localparam int CNT_W = 8;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic             ovf;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             sig_in;
    logic             start = 1'b0;
    logic             busy;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] period;
    logic             overflow;

    logic gen_en = 1'b0;
    logic gen_sig = 1'b0;
    logic man_sig = 1'b0;
    int   gen_hi = 8;
    int   gen_lo = 8;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    assign sig_in = gen_en ? gen_sig : man_sig;

    period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .period    (period),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    // Waveform source: low for gen_lo cycles, high for gen_hi cycles, starting low.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clock);
            if (!gen_en) begin
                gen_sig = 1'b0;
                ph = 0;
            end else begin
                ph++;
                if (gen_sig && ph >= gen_hi) begin
                    gen_sig = 1'b0;
                    ph = 0;
                end else if (!gen_sig && ph >= gen_lo) begin
                    gen_sig = 1'b1;
                    ph = 0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int nbusy, output bit ok);
        nbusy = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        man_sig = 1'b0;
        gen_en = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if ({busy, out_valid, period, overflow} !== '0) begin
                errors++;
                $display("FAIL reset_defaults cycle %0d: busy=%b valid=%b period=%0d ovf=%b, want all 0",
                         i, busy, out_valid, period, overflow);
            end
        end
    endtask

    task automatic measure_divided(input int half, input string name);
        exp_t e;
        int   nb;
        bit   ok;
        gen_hi = half;
        gen_lo = half;
        gen_en = 1'b1;
        repeat (5) @(negedge clock);
        sb_q.push_back('{period: CNT_W'(2 * half), ovf: 1'b0});
        pulse_start();
        wait_valid(200, nb, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b, want 1 within 200 cycles", name, out_valid);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (period !== e.period) begin
                errors++;
                $display("FAIL %s_period: got %0d want %0d", name, period, e.period);
            end
            checks++;
            if (overflow !== e.ovf) begin
                errors++;
                $display("FAIL %s_overflow: got %b want %b", name, overflow, e.ovf);
            end
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_valid_one_cycle: out_valid=%b want 0", name, out_valid);
            end
        end
        sb_q.delete();
        gen_en = 1'b0;
    endtask

    task automatic test_divided_clock();
        measure_divided(8, "div16");
        measure_divided(1, "div2");
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   nb;
        bit   ok;
        bit   bad;
        gen_hi = 3;
        gen_lo = 7;
        gen_en = 1'b1;
        out_ready = 1'b0;
        repeat (4) @(negedge clock);
        sb_q.push_back('{period: CNT_W'(10), ovf: 1'b0});
        pulse_start();
        wait_valid(200, nb, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: out_valid=%b, want 1 within 200 cycles", out_valid);
        end else begin
            e = sb_q.pop_front();
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (out_valid !== 1'b1 || period !== e.period || overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d: valid=%b period=%0d ovf=%b want 1/%0d/%b",
                             i, out_valid, period, overflow, e.period, e.ovf);
                end
                if (i == 5) start = 1'b1;
                if (i == 6) start = 1'b0;
                @(negedge clock);
            end
            out_ready = 1'b1;
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_release: out_valid=%b want 0", out_valid);
            end
            bad = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (busy || out_valid) bad = 1'b1;
                @(negedge clock);
            end
            checks++;
            if (bad !== 1'b0) begin
                errors++;
                $display("FAIL bp_start_ignored: activity=%b want 0 (no second measurement)", bad);
            end
        end
        sb_q.delete();
        gen_en = 1'b0;
    endtask

    task automatic test_overflow();
        exp_t e;
        int   nb;
        bit   ok;
        gen_en = 1'b0;
        man_sig = 1'b0;
        repeat (4) @(negedge clock);
        sb_q.push_back('{period: 8'hFF, ovf: 1'b1});
        pulse_start();
        wait_valid(600, nb, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_arm_timeout: out_valid=%b, want 1 within 600 cycles", out_valid);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (nb != 255) begin
                errors++;
                $display("FAIL ovf_arm_cycles: got %0d busy cycles want 255", nb);
            end
            checks++;
            if (period !== e.period || overflow !== e.ovf) begin
                errors++;
                $display("FAIL ovf_arm_result: period=%0d ovf=%b want %0d/%b", period, overflow, e.period, e.ovf);
            end
        end
        repeat (3) @(negedge clock);
        sb_q.push_back('{period: 8'hFF, ovf: 1'b1});
        pulse_start();
        repeat (5) @(negedge clock);
        man_sig = 1'b1;
        wait_valid(600, nb, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_count_timeout: out_valid=%b, want 1 within 600 cycles", out_valid);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (nb <= 255) begin
                errors++;
                $display("FAIL ovf_count_cycles: got %0d busy cycles want more than 255", nb);
            end
            checks++;
            if (period !== e.period || overflow !== e.ovf) begin
                errors++;
                $display("FAIL ovf_count_result: period=%0d ovf=%b want %0d/%b", period, overflow, e.period, e.ovf);
            end
        end
        sb_q.delete();
        repeat (3) @(negedge clock);
        man_sig = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   nb;
        bit   ok;
        bit   seen;
        bit   prev;
        bit   bad;
        gen_hi = 8;
        gen_lo = 8;
        gen_en = 1'b1;
        repeat (3) @(negedge clock);
        sb_q.push_back('{period: CNT_W'(16), ovf: 1'b0});
        pulse_start();
        seen = 1'b0;
        prev = gen_sig;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (gen_sig && !prev) begin
                seen = 1'b1;
                break;
            end
            prev = gen_sig;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_edge_timeout: gen_sig=%b, want a rising edge within 40 cycles", gen_sig);
        end
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: busy=%b valid=%b want 0/0", busy, out_valid);
        end
        void'(sb_q.pop_back());
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy || out_valid) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_result: activity=%b want 0", bad);
        end
        sb_q.push_back('{period: CNT_W'(16), ovf: 1'b0});
        pulse_start();
        wait_valid(200, nb, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_remeasure_timeout: out_valid=%b, want 1 within 200 cycles", out_valid);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (period !== e.period || overflow !== e.ovf) begin
                errors++;
                $display("FAIL mid_remeasure: period=%0d ovf=%b want %0d/%b", period, overflow, e.period, e.ovf);
            end
        end
        sb_q.delete();
        gen_en = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_sig_high();
        exp_t e;
        int   nb;
        bit   ok;
        gen_en = 1'b0;
        man_sig = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        gen_hi = 6;
        gen_lo = 6;
        sb_q.push_back('{period: CNT_W'(12), ovf: 1'b0});
        pulse_start();
        gen_en = 1'b1;
        wait_valid(200, nb, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sighigh_timeout: out_valid=%b, want 1 within 200 cycles", out_valid);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (period !== e.period || overflow !== e.ovf) begin
                errors++;
                $display("FAIL sighigh_result: period=%0d ovf=%b want %0d/%b", period, overflow, e.period, e.ovf);
            end
        end
        sb_q.delete();
        gen_en = 1'b0;
        man_sig = 1'b0;
    endtask

    initial begin
        test_reset();
        test_divided_clock();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_reset_sig_high();
        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
